// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared FSM state encoding and BCD digit constants
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_ADD_THRESH = 4'd5;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3_digit: combinational double-dabble correction, adds 3 to a BCD digit that is 5 or more
module bcd_add3_digit
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= BCD_ADD_THRESH) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to BCD converter, one shift per clock; optional leading-zero blanking via LZ_BLANK_EN
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              bin,
    input  logic                          start,
    output logic                          ready,
    output logic                          done_tick,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          ovf,
    output logic [DIGITS-1:0]             blank
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = ((WIDTH > BW) ? WIDTH : BW) + 1;

    function automatic logic [PW-1:0] pow10(input int n);
        logic [PW-1:0] p;
        p = PW'(1);
        for (int i = 0; i < n; i++) p = p * PW'(10);
        return p;
    endfunction

    // Smallest value that no longer fits in DIGITS decimal digits
    localparam logic [PW-1:0] P10 = pow10(DIGITS);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]   r_work;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf_next;
    logic [BW-1:0]   r_bcd;
    logic            r_ovf;
    logic [DIGITS-1:0] r_blank;
    logic            r_done;
    logic [BW-1:0]   w_adj;
    logic [DIGITS-1:0] w_blank;
    logic            w_ovf_cmp;
    logic            w_load;
    logic            w_shift_en;
    logic            w_commit;

    assign w_ovf_cmp = ({{(PW-WIDTH){1'b0}}, bin} >= P10);

    // Per-digit add-3 correction applied before every shift
    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3_digit u_add3 (
            .i_digit (r_work[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .o_digit (w_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

`ifdef LZ_BLANK_EN
    // Digit i is blanked when it and every higher digit are zero; units digit always shown
    assign w_blank[0] = 1'b0;
    for (genvar i = 1; i < DIGITS; i++) begin : g_blank
        assign w_blank[i] = !r_ovf_next && (r_work[BW-1:BCD_DIGIT_W*i] == '0);
    end
`else
    assign w_blank = '0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift_en  = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load      = start;
                w_state_nxt = start ? ST_SHIFT : ST_IDLE;
            end
            ST_SHIFT: begin
                w_shift_en  = 1'b1;
                w_state_nxt = (r_cnt == CW'(1)) ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shift/work registers and the result registers, which update only together at commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_ovf_next <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_blank    <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift    <= bin;
                r_work     <= '0;
                r_cnt      <= CW'(WIDTH);
                r_ovf_next <= w_ovf_cmp;
            end else if (w_shift_en) begin
                r_work  <= {w_adj[BW-2:0], r_shift[WIDTH-1]};
                r_shift <= r_shift << 1;
                r_cnt   <= r_cnt - CW'(1);
            end
            if (w_commit) begin
                r_bcd   <= r_work;
                r_ovf   <= r_ovf_next;
                r_blank <= w_blank;
            end
            r_done <= w_commit;
        end
    end

    assign ready     = (r_state == ST_IDLE);
    assign done_tick = r_done;
    assign bcd       = r_bcd;
    assign ovf       = r_ovf;
    assign blank     = r_blank;

endmodule
